// File: rtl/gc_dualrail_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gc_seq_pkg
// Purpose  : Shared types and dual-rail code constants for the gC_imp
//            transaction sequencer and its actuator synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
package gc_seq_pkg;

    // Sequencer states, one per phase of a four-phase dual-rail transaction.
    typedef enum logic [3:0] {
        IDLE           = 4'd0,
        DRIVE_SENSOR   = 4'd1,
        DRIVE_START    = 4'd2,
        WAIT_VALID     = 4'd3,
        RELEASE_SENSOR = 4'd4,
        RELEASE_START  = 4'd5,
        WAIT_NULL      = 4'd6,
        ABORT          = 4'd7,
        RESPOND        = 4'd8
    } seq_state_t;

    // Dual-rail codewords, bit order {rail_1, rail_0}.
    localparam logic [1:0] NULL    = 2'b00;
    localparam logic [1:0] ZERO    = 2'b01;
    localparam logic [1:0] ONE     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    // Single-rail bit to its dual-rail data codeword.
    function automatic logic [1:0] dr_encode(input logic bit_val);
        return bit_val ? ONE : ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gc_dualrail_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module   : gc_dualrail_sync
// Purpose  : Multi-flop synchronizer for an asynchronous dual-rail pair plus
//            null / valid / illegal decode of the synchronized codeword.
//            Both rails move through the chain together, so a codeword is
//            always decoded from a single sampling instant.
// Revision : 1.0 - initial release
// ============================================================================
module gc_dualrail_sync
    import gc_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_rail_0,
    input  logic i_rail_1,
    output logic o_is_null,
    output logic o_is_valid,
    output logic o_is_illegal,
    output logic o_value
);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [SYNC_STAGES-1:0][1:0] sync_d;
    logic [1:0]                  w_code;

    // Shift the raw pair in at stage 0; the oldest sample sits at the top.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {i_rail_1, i_rail_0}};
    end

    // Synchronizer chain; reset to the null spacer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign w_code       = sync_q[SYNC_STAGES-1];
    assign o_is_null    = (w_code == NULL);
    assign o_is_valid   = (w_code == ZERO) || (w_code == ONE);
    assign o_is_illegal = (w_code == ILLEGAL);
    assign o_value      = w_code[1];

endmodule
`default_nettype wire

// File: rtl/gc_dualrail_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gc_dualrail_sequencer
// Purpose  : Sequences one request through the asynchronous dual-rail gC_imp
//            circuit: raises the sensor rail, then the startSignal rail,
//            waits for a valid actuator code, returns both pairs to the null
//            spacer one at a time and reports the result (or an error on
//            timeout / illegal code) over a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module gc_dualrail_sequencer
    import gc_seq_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_sensor,
    input  logic req_start,
    output logic rsp_valid,
    input  logic rsp_ready,
    output logic rsp_actuator,
    output logic rsp_error,
    output logic sensor_0,
    output logic sensor_1,
    output logic startSignal_0,
    output logic startSignal_1,
    input  logic actuator_0,
    input  logic actuator_1,
    output logic busy
);

    localparam int                   c_tmo_w     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int                   c_setup_w   = $clog2(SETUP_CYCLES + 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_max   = c_tmo_w'(TIMEOUT_CYCLES);
    localparam logic [c_tmo_w-1:0]   c_tmo_one   = c_tmo_w'(1);
    localparam logic [c_setup_w-1:0] c_setup_max = c_setup_w'(SETUP_CYCLES);
    localparam logic [c_setup_w-1:0] c_setup_one = c_setup_w'(1);

    seq_state_t           state_q, state_d;
    logic                 start_bit_q, start_bit_d;
    logic [1:0]           sensor_rail_q, sensor_rail_d;
    logic [1:0]           start_rail_q, start_rail_d;
    logic [c_setup_w-1:0] setup_cnt_q, setup_cnt_d;
    logic [c_tmo_w-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                 result_q, result_d;
    logic                 error_q, error_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_actuator_q, rsp_actuator_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 busy_q, busy_d;

    logic                 a_null, a_valid, a_illegal, a_value;
    logic [c_setup_w-1:0] w_setup_inc;
    logic [c_tmo_w-1:0]   w_tmo_inc;

    gc_dualrail_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_act_sync (
        .clk          (clk),
        .reset        (reset),
        .i_rail_0     (actuator_0),
        .i_rail_1     (actuator_1),
        .o_is_null    (a_null),
        .o_is_valid   (a_valid),
        .o_is_illegal (a_illegal),
        .o_value      (a_value)
    );

    // Both counters saturate at their limit instead of wrapping.
    assign w_setup_inc = (setup_cnt_q == c_setup_max) ? setup_cnt_q : setup_cnt_q + 1'b1;
    assign w_tmo_inc   = (tmo_cnt_q == c_tmo_max) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d        = state_q;
        start_bit_d    = start_bit_q;
        sensor_rail_d  = sensor_rail_q;
        start_rail_d   = start_rail_q;
        setup_cnt_d    = setup_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        result_d       = result_q;
        error_d        = error_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_actuator_d = rsp_actuator_q;
        rsp_error_d    = rsp_error_q;

        case (state_q)
            IDLE: begin
                // req_ready_q already implies the actuator was null last
                // cycle; honouring it keeps the handshake the requester saw.
                if (req_valid && req_ready_q) begin
                    start_bit_d   = req_start;
                    sensor_rail_d = dr_encode(req_sensor);
                    setup_cnt_d   = c_setup_one;
                    state_d       = DRIVE_SENSOR;
                end
            end
            DRIVE_SENSOR: begin
                if (setup_cnt_q == c_setup_max) begin
                    start_rail_d = dr_encode(start_bit_q);
                    tmo_cnt_d    = c_tmo_one;
                    state_d      = DRIVE_START;
                end else begin
                    setup_cnt_d = w_setup_inc;
                end
            end
            DRIVE_START: begin
                tmo_cnt_d = w_tmo_inc;
                state_d   = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (a_valid) begin
                    result_d      = a_value;
                    sensor_rail_d = NULL;
                    setup_cnt_d   = c_setup_one;
                    state_d       = RELEASE_SENSOR;
                end else if (a_illegal || (tmo_cnt_q == c_tmo_max)) begin
                    error_d       = 1'b1;
                    sensor_rail_d = NULL;
                    start_rail_d  = NULL;
                    state_d       = ABORT;
                end else begin
                    tmo_cnt_d = w_tmo_inc;
                end
            end
            RELEASE_SENSOR: begin
                if (setup_cnt_q == c_setup_max) begin
                    start_rail_d = NULL;
                    tmo_cnt_d    = c_tmo_one;
                    state_d      = RELEASE_START;
                end else begin
                    setup_cnt_d = w_setup_inc;
                end
            end
            RELEASE_START: begin
                tmo_cnt_d = w_tmo_inc;
                state_d   = WAIT_NULL;
            end
            WAIT_NULL: begin
                if (a_null) begin
                    rsp_valid_d    = 1'b1;
                    rsp_actuator_d = result_q & ~error_q;
                    rsp_error_d    = error_q;
                    state_d        = RESPOND;
                end else if (tmo_cnt_q == c_tmo_max) begin
                    error_d       = 1'b1;
                    sensor_rail_d = NULL;
                    start_rail_d  = NULL;
                    state_d       = ABORT;
                end else begin
                    tmo_cnt_d = w_tmo_inc;
                end
            end
            ABORT: begin
                // No timeout here: the circuit must settle before reuse.
                if (a_null) begin
                    rsp_valid_d    = 1'b1;
                    rsp_actuator_d = result_q & ~error_q;
                    rsp_error_d    = error_q;
                    state_d        = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d    = 1'b0;
                    rsp_actuator_d = 1'b0;
                    rsp_error_d    = 1'b0;
                    error_d        = 1'b0;
                    result_d       = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                sensor_rail_d = NULL;
                start_rail_d  = NULL;
                state_d       = IDLE;
            end
        endcase

        // Ready only in IDLE with a settled circuit; never in the handshake
        // cycle itself, so a response and a new accept cannot overlap.
        req_ready_d = (state_d == IDLE) && a_null;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset to the null spacer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            start_bit_q    <= 1'b0;
            sensor_rail_q  <= NULL;
            start_rail_q   <= NULL;
            setup_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            result_q       <= 1'b0;
            error_q        <= 1'b0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_actuator_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_bit_q    <= start_bit_d;
            sensor_rail_q  <= sensor_rail_d;
            start_rail_q   <= start_rail_d;
            setup_cnt_q    <= setup_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            result_q       <= result_d;
            error_q        <= error_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_actuator_q <= rsp_actuator_d;
            rsp_error_q    <= rsp_error_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_actuator  = rsp_actuator_q;
    assign rsp_error     = rsp_error_q;
    assign sensor_0      = sensor_rail_q[0];
    assign sensor_1      = sensor_rail_q[1];
    assign startSignal_0 = start_rail_q[0];
    assign startSignal_1 = start_rail_q[1];
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gc_dualrail_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gc_dualrail_sequencer
// Purpose  : Self-checking bench for gc_dualrail_sequencer with a behavioural
//            gC circuit model (actuator = sensor XOR startSignal after a fixed
//            delay) and directed plus randomized transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gc_dualrail_sequencer;
    import gc_seq_pkg::*;

    localparam int SETUP    = 4;
    localparam int TMO      = 16;
    localparam int SYNC     = 2;
    localparam int GC_DELAY = 10;

    typedef enum int {GC_NORMAL, GC_SILENT, GC_ILLEGAL, GC_FORCE} gc_mode_e;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_sensor = 1'b0, req_start = 1'b0, rsp_ready = 1'b0;
    logic req_ready, rsp_valid, rsp_actuator, rsp_error, busy;
    logic sensor_0, sensor_1, startSignal_0, startSignal_1;
    logic actuator_0, actuator_1;

    int total = 0;
    int bad = 0;
    int exp_accepts = 0;

    gc_mode_e   gc_mode = GC_NORMAL;
    logic [1:0] force_code = 2'b00;
    logic [1:0] act = 2'b00;
    int         gc_cnt = 0;
    bit         abort_ok = 1'b0;
    int         rail_viol = 0;
    int         hs_count = 0;
    logic [1:0] prev_s = 2'b00, prev_t = 2'b00;

    wire [1:0] s_pair = {sensor_1, sensor_0};
    wire [1:0] t_pair = {startSignal_1, startSignal_0};
    wire [3:0] rails  = {sensor_1, sensor_0, startSignal_1, startSignal_0};
    wire in_valid = (sensor_0 ^ sensor_1) && (startSignal_0 ^ startSignal_1);
    wire in_null  = (rails == 4'b0000);

    assign actuator_0 = act[0];
    assign actuator_1 = act[1];

    always #5 clk = ~clk;

    gc_dualrail_sequencer #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sensor    (req_sensor),
        .req_start     (req_start),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_actuator  (rsp_actuator),
        .rsp_error     (rsp_error),
        .sensor_0      (sensor_0),
        .sensor_1      (sensor_1),
        .startSignal_0 (startSignal_0),
        .startSignal_1 (startSignal_1),
        .actuator_0    (actuator_0),
        .actuator_1    (actuator_1),
        .busy          (busy)
    );

    // Behavioural gC circuit: answers GC_DELAY cycles after both inputs are
    // valid and returns to null GC_DELAY cycles after both inputs are null.
    always @(negedge clk) begin
        if (gc_mode == GC_FORCE) begin
            act    <= force_code;
            gc_cnt <= 0;
        end else if (in_valid && act == 2'b00 && gc_mode != GC_SILENT) begin
            if (gc_cnt == GC_DELAY - 1) begin
                act    <= (gc_mode == GC_ILLEGAL) ? 2'b11
                          : ((sensor_1 ^ startSignal_1) ? 2'b10 : 2'b01);
                gc_cnt <= 0;
            end else begin
                gc_cnt <= gc_cnt + 1;
            end
        end else if (in_null && act != 2'b00) begin
            if (gc_cnt == GC_DELAY - 1) begin
                act    <= 2'b00;
                gc_cnt <= 0;
            end else begin
                gc_cnt <= gc_cnt + 1;
            end
        end else begin
            gc_cnt <= 0;
        end
    end

    // Rail-protocol watcher and request-handshake counter.
    always @(negedge clk) begin
        if (s_pair == 2'b11 || t_pair == 2'b11) rail_viol++;
        if (s_pair != prev_s && t_pair != prev_t && !(abort_ok && rails == 4'b0000)) rail_viol++;
        prev_s = s_pair;
        prev_t = t_pair;
        if (req_valid && req_ready) hs_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for it to be accepted and check the rail timing.
    task automatic run_front(input logic s, input logic st, input string tag);
        int n;
        req_sensor = s;
        req_start  = st;
        req_valid  = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, " accept wait"}, 32'(n < 300), 1);
        tick();
        req_valid = 1'b0;
        exp_accepts++;
        chk({tag, " sensor rail"}, s_pair, s ? 2'b10 : 2'b01);
        chk({tag, " start rail idle"}, t_pair, 2'b00);
        chk({tag, " busy"}, busy, 1);
        repeat (SETUP - 1) tick();
        chk({tag, " start rail early"}, t_pair, 2'b00);
        tick();
        chk({tag, " start rail"}, t_pair, st ? 2'b10 : 2'b01);
        chk({tag, " sensor rail held"}, s_pair, s ? 2'b10 : 2'b01);
    endtask

    // Wait for the response, check it, hold rsp_ready low for a while, consume it.
    task automatic finish_rsp(input logic exp_act, input logic exp_err,
                              input int hold, input string tag);
        int n;
        int instab;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_actuator"}, rsp_actuator, exp_act);
        chk({tag, " rsp_error"}, rsp_error, exp_err);
        chk({tag, " rails null"}, rails, 4'b0000);
        chk({tag, " req_ready low"}, req_ready, 0);
        instab = 0;
        repeat (hold) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_actuator !== exp_act || rsp_error !== exp_err
                || req_ready !== 1'b0) instab++;
        end
        chk({tag, " rsp stable"}, instab, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " rsp dropped"}, rsp_valid, 0);
        chk({tag, " busy cleared"}, busy, 0);
    endtask

    initial begin
        int n;
        int instab;
        int hs0;
        logic s, st;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rails", rails, 4'b0000);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_actuator", rsp_actuator, 0);
        chk("reset rsp_error", rsp_error, 0);
        chk("reset busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("idle req_ready", req_ready, 1);

        // Basic transaction: sensor=1, start=0 -> actuator 1.
        run_front(1'b1, 1'b0, "basic");
        finish_rsp(1'b1, 1'b0, 0, "basic");

        // Circuit never answers: timeout, rails drop TMO cycles after start rail.
        gc_mode  = GC_SILENT;
        abort_ok = 1'b1;
        run_front(1'b0, 1'b1, "tmo");
        repeat (TMO - 1) tick();
        chk("tmo rails before limit", rails, 4'b0110);
        tick();
        chk("tmo rails dropped", rails, 4'b0000);
        chk("tmo busy", busy, 1);
        finish_rsp(1'b0, 1'b1, 0, "tmo");
        gc_mode  = GC_NORMAL;
        abort_ok = 1'b0;
        run_front(1'b1, 1'b1, "post-tmo");
        finish_rsp(1'b0, 1'b0, 0, "post-tmo");

        // Illegal actuator code: abort, wait for null, error response.
        gc_mode  = GC_ILLEGAL;
        abort_ok = 1'b1;
        run_front(1'b1, 1'b1, "ill");
        n = 0;
        while (rails !== 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        chk("ill rails dropped", 32'(n < 100), 1);
        chk("ill busy in abort", busy, 1);
        chk("ill no rsp while illegal", rsp_valid, 0);
        finish_rsp(1'b0, 1'b1, 0, "ill");
        gc_mode  = GC_NORMAL;
        abort_ok = 1'b0;

        // Actuator stuck non-null in IDLE blocks acceptance.
        gc_mode    = GC_FORCE;
        force_code = 2'b01;
        repeat (SYNC + 2) tick();
        req_sensor = 1'b0;
        req_start  = 1'b0;
        req_valid  = 1'b1;
        instab = 0;
        repeat (8) begin
            tick();
            if (req_ready !== 1'b0 || rails !== 4'b0000 || busy !== 1'b0) instab++;
        end
        chk("hold blocked", instab, 0);
        force_code = 2'b00;
        repeat (SYNC) tick();
        chk("hold ready still low", req_ready, 0);
        tick();
        chk("hold ready rises", req_ready, 1);
        gc_mode = GC_NORMAL;
        run_front(1'b0, 1'b0, "hold");
        finish_rsp(1'b0, 1'b0, 0, "hold");

        // Reset during WAIT_VALID.
        run_front(1'b1, 1'b0, "rst");
        repeat (3) tick();
        abort_ok = 1'b1;
        reset = 1'b1;
        tick();
        chk("rst rails", rails, 4'b0000);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst busy", busy, 0);
        reset = 1'b0;
        tick();
        abort_ok = 1'b0;
        run_front(1'b0, 1'b1, "post-rst");
        finish_rsp(1'b1, 1'b0, 0, "post-rst");

        // Response back-pressure with a new request waiting.
        run_front(1'b1, 1'b0, "bp");
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("bp rsp_valid", rsp_valid, 1);
        chk("bp rsp_actuator", rsp_actuator, 1);
        chk("bp rsp_error", rsp_error, 0);
        hs0 = hs_count;
        req_sensor = 1'b1;
        req_start  = 1'b1;
        req_valid  = 1'b1;
        instab = 0;
        repeat (20) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_actuator !== 1'b1 || rsp_error !== 1'b0
                || req_ready !== 1'b0) instab++;
        end
        chk("bp stall stable", instab, 0);
        chk("bp no accept during stall", hs_count - hs0, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp rsp consumed", rsp_valid, 0);
        run_front(1'b1, 1'b1, "bp-next");
        finish_rsp(1'b0, 1'b0, 0, "bp-next");
        chk("bp exactly one accept", hs_count - hs0, 1);

        // Randomized transactions against the reference function.
        repeat (12) begin
            s  = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            run_front(s, st, "rand");
            finish_rsp(s ^ st, 1'b0, int'($urandom_range(0, 5)), "rand");
        end

        chk("rail protocol violations", rail_viol, 0);
        chk("total accepts", hs_count, exp_accepts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=time limit reached expected=finish before limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
